fft2d_seq_ctrl: RTL and testbench
=================================

FFT2D_SEQ_CTRL -- requirements
Module: fft2d_seq_ctrl

Interface
REQ-001 Parameter N, default 128: FFT points per frame; image is N x N; power of two, 4..1024.
REQ-002 Parameter LOG2N, default 7: log2(N).
REQ-003 Parameter FWD_CFG, default 16'h0001: config word driven to the FFT core for both passes (forward transform).
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: pulse to begin one 2D transform; honoured only in IDLE.
REQ-007 Ports busy and done, output, 1 each: busy is high outside IDLE; done is a one-cycle pulse at completion.
REQ-008 Port pass, output, 1: 0 = row pass (ROM source), 1 = column pass (buffer source).
REQ-009 Ports cfg_tdata (16), cfg_tvalid (1), output; cfg_tready (1), input: FFT core config channel.
REQ-010 Ports rd_en (1) and rd_addr (2*LOG2N), output: source memory read; data returns one cycle after rd_en; memory holds its output while rd_en is low.
REQ-011 Ports s_tvalid (1) and s_tlast (1), output; s_tready (1), input: FFT core input-channel control; data path is external.
REQ-012 Ports m_tvalid (1) and m_tlast (1), input: FFT core output channel; m_tready is tied high externally.
REQ-013 Ports wr_en (1) and wr_addr (2*LOG2N), output: writes the FFT output sample; pass selects the buffer (0) or result memory (1).
REQ-014 Port err, output, 1: sticky framing error flag.

Function
REQ-015 States: IDLE, CFG0, RUN0, CFG1, RUN1, FIN.
- IDLE -> CFG0 on start.
- CFGx -> RUNx on the cycle cfg_tvalid && cfg_tready.
- RUN0 -> CFG1 and RUN1 -> FIN on acceptance of output sample N*N-1.
- FIN -> IDLE after one cycle.
REQ-016 In CFG0/CFG1: cfg_tdata = FWD_CFG; cfg_tvalid is held high until cfg_tready; cfg_tvalid is low in every other state.
REQ-017 Feed counter fc (2*LOG2N bits) resets to 0 on entry to each RUN state.
- advance = (fc < N*N issued) && (!s_tvalid || s_tready).
- rd_en = advance; fc increments on advance.
REQ-018 s_tvalid is set the cycle after advance and cleared on the s_tready handshake when no new advance occurs; it never drops without a handshake.
REQ-019 s_tlast is registered alongside s_tvalid: high exactly for the sample whose in-frame index (fc mod N) = N-1.
REQ-020 Read addressing:
- RUN0: rd_addr = fc (linear row order).
- RUN1: rd_addr = {fc[LOG2N-1:0], fc[2*LOG2N-1:LOG2N]} (transposed).
REQ-021 Output counter oc resets to 0 on entry to each RUN state.
- Each cycle with m_tvalid: wr_en = 1, wr_addr = oc, oc increments.
- wr_en is 0 otherwise.
REQ-022 A pass ends only after all N*N outputs are written; RUN1 never starts while pass-0 output is incomplete.
REQ-023 Framing check: err is set if m_tvalid && (m_tlast != (oc mod N == N-1)).
- err is cleared only by reset or by accepted start.
- A framing error does not alter sequencing.
REQ-024 start while busy is ignored; start coincident with FIN is ignored.
REQ-025 m_tvalid in IDLE, CFG0 or CFG1 is ignored: no write, no counter change.
REQ-026 At fc = N*N (fc wraps to 0 in 2*LOG2N bits): feeding stops; a sticky issued-all flag prevents wrap re-feed.

Reset
REQ-027 Reset low forces, asynchronously: IDLE, fc = 0, oc = 0, issued-all = 0, err = 0.
REQ-028 Outputs during and after reset: busy, done, pass, cfg_tvalid, rd_en, s_tvalid, s_tlast, wr_en = 0; rd_addr, wr_addr = 0; cfg_tdata = FWD_CFG.
REQ-029 Reset mid-transform abandons the transform; no done pulse; next start begins at CFG0.

Verification
REQ-030 N=4, cfg_tready high, s_tready high, model core with 5-cycle latency and correct tlast, start pulse:
- row pass: rd_addr sequence 0..15, s_tlast on samples 3, 7, 11, 15;
- column pass: rd_addr sequence 0, 4, 8, 12, 1, 5, ... 15;
- 32 total wr_en pulses; one done pulse; err = 0.
REQ-031 cfg_tready held low 10 cycles in CFG0 -> cfg_tvalid = 1 and cfg_tdata = 16'h0001 held stable for all 10 cycles; rd_en = 0 throughout.
REQ-032 Random s_tready, 50% duty -> rd_addr and s_tlast sequences identical to REQ-030; no sample dropped or duplicated; s_tvalid never drops without a handshake.
REQ-033 Model asserts m_tlast on output index 2 of row pass -> err = 1 from the next cycle; transform still completes; next start clears err.
REQ-034 Reset asserted at oc = 7 in RUN0 -> all outputs 0 immediately; a later start produces a full, correct transform.
REQ-035 start pulsed in RUN1 and in FIN -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/fft2d_seq_ctrl.sv
// rtl/fft2d_seq_ctrl.sv - two-pass (row then column) 2D FFT sequencing controller
module fft2d_seq_ctrl #(
  parameter int          N       = 128,
  parameter int          LOG2N   = 7,
  parameter logic [15:0] FWD_CFG = 16'h0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        cfg_tdata,
  output logic               cfg_tvalid,
  input  logic               cfg_tready,
  output logic               rd_en,
  output logic [2*LOG2N-1:0] rd_addr,
  output logic               s_tvalid,
  output logic               s_tlast,
  input  logic               s_tready,
  input  logic               m_tvalid,
  input  logic               m_tlast,
  output logic               wr_en,
  output logic [2*LOG2N-1:0] wr_addr,
  output logic               err
);

  localparam int             AW            = 2 * LOG2N;
  localparam logic [AW-1:0]  LAST_SAMPLE   = {AW{1'b1}};
  localparam logic [AW-1:0]  ONE           = AW'(1);
  localparam logic [LOG2N-1:0] LAST_IN_FRAME = LOG2N'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG0,
    S_RUN0,
    S_CFG1,
    S_RUN1,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] fc;
  logic [AW-1:0] oc;
  logic          issued_all;
  logic          in_cfg;
  logic          in_run;
  logic          advance;
  logic          out_acc;
  logic          pass_end;
  logic          start_acc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    pass       = 1'b0;
    cfg_tvalid = 1'b0;
    in_cfg     = 1'b0;
    in_run     = 1'b0;
    start_acc  = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        start_acc = start;
        if (start) state_nxt = S_CFG0;
      end
      S_CFG0: begin
        cfg_tvalid = 1'b1;
        in_cfg     = 1'b1;
        if (cfg_tready) state_nxt = S_RUN0;
      end
      S_RUN0: begin
        in_run = 1'b1;
        if (pass_end) state_nxt = S_CFG1;
      end
      S_CFG1: begin
        pass       = 1'b1;
        cfg_tvalid = 1'b1;
        in_cfg     = 1'b1;
        if (cfg_tready) state_nxt = S_RUN1;
      end
      S_RUN1: begin
        pass   = 1'b1;
        in_run = 1'b1;
        if (pass_end) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Feed/drain qualifiers and memory-facing addresses
  always_comb begin
    cfg_tdata = FWD_CFG;
    advance   = in_run && !issued_all && (!s_tvalid || s_tready);
    out_acc   = in_run && m_tvalid;
    pass_end  = out_acc && (oc == LAST_SAMPLE);
    rd_en     = advance;
    wr_en     = out_acc;
    wr_addr   = oc;
    // Column pass walks the row-major buffer transposed
    if (pass) rd_addr = {fc[LOG2N-1:0], fc[AW-1:LOG2N]};
    else      rd_addr = fc;
  end

  // Feed counter; issued_all stops re-feeding once fc wraps past the last sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc         <= '0;
      issued_all <= 1'b0;
    end else if (in_cfg) begin
      fc         <= '0;
      issued_all <= 1'b0;
    end else if (advance) begin
      fc <= fc + ONE;
      if (fc == LAST_SAMPLE) issued_all <= 1'b1;
    end
  end

  // Input-channel valid/last: the read data appears one cycle after rd_en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_tvalid <= 1'b0;
      s_tlast  <= 1'b0;
    end else if (advance) begin
      s_tvalid <= 1'b1;
      s_tlast  <= (fc[LOG2N-1:0] == LAST_IN_FRAME);
    end else if (s_tready) begin
      s_tvalid <= 1'b0;
      s_tlast  <= 1'b0;
    end
  end

  // Output counter, one write address per accepted core output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       oc <= '0;
    else if (in_cfg)  oc <= '0;
    else if (out_acc) oc <= oc + ONE;
  end

  // Sticky framing error; cleared only by reset or an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (start_acc)
      err <= 1'b0;
    else if (out_acc && (m_tlast != (oc[LOG2N-1:0] == LAST_IN_FRAME)))
      err <= 1'b1;
  end

endmodule

// File: tb/tb_fft2d_seq_ctrl.sv
// tb/tb_fft2d_seq_ctrl.sv - self-checking bench for fft2d_seq_ctrl with N=4
module tb_fft2d_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy, done, pass;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid, cfg_tready;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        s_tvalid, s_tlast, s_tready;
  logic        m_tvalid, m_tlast;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        err;

  fft2d_seq_ctrl #(.N(4), .LOG2N(2), .FWD_CFG(16'h0001)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .rd_en(rd_en), .rd_addr(rd_addr), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .wr_en(wr_en), .wr_addr(wr_addr), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor/model shared state
  logic [3:0] rd_q[$];
  bit         tl_q[$];
  int         hs_cnt, wr_cnt, done_cnt, drop_cnt;
  bit         hs_sample;
  bit         prev_v, prev_r;
  bit         rnd_ready, inj;
  int         out_idx;
  logic [4:0] pipe;
  bit         probe_arm, err_at2, err_next;

  typedef struct {
    bit rnd;
    bit inj;
    bit exp_err;
    bit exp_at2;
    bit exp_next;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_v    = 1'b0;
        prev_r    = 1'b0;
        hs_sample = 1'b0;
        probe_arm = 1'b0;
      end else begin
        if (rd_en) rd_q.push_back(rd_addr);
        hs_sample = s_tvalid && s_tready;
        if (hs_sample) begin
          tl_q.push_back(s_tlast);
          hs_cnt++;
        end
        if (prev_v && !prev_r && !s_tvalid) drop_cnt++;
        prev_v = s_tvalid;
        prev_r = s_tready;
        if (probe_arm) begin
          err_next  = err;
          probe_arm = 1'b0;
        end
        if (wr_en) begin
          wr_cnt++;
          if (!pass && wr_addr == 4'd2) begin
            err_at2   = err;
            probe_arm = 1'b1;
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // FFT core model: 5-cycle latency, tlast on every 4th output, optional bad tlast at index 2
  initial begin
    pipe     = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        pipe     = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
      end else begin
        pipe     = {pipe[3:0], hs_sample};
        m_tvalid = pipe[4];
        if (pipe[4]) begin
          m_tlast = ((out_idx % 4) == 3) || (inj && out_idx == 2);
          out_idx++;
        end else begin
          m_tlast = 1'b0;
        end
      end
      s_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_stats();
    rd_q.delete();
    tl_q.delete();
    hs_cnt = 0; wr_cnt = 0; done_cnt = 0; drop_cnt = 0;
    out_idx = 0; err_at2 = 1'b0; err_next = 1'b0; probe_arm = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_cnt >= 1) begin ok = 1'b1; break; end
    end
    chk({name, "_done_timeout"}, ok, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_write(input bit p, input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wr_en && pass == p && wr_addr == 4'(a)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_full(input string name);
    int exp_a;
    chk({name, "_wr_cnt"}, wr_cnt, 32);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_hs_cnt"}, hs_cnt, 32);
    chk({name, "_drop"}, drop_cnt, 0);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_rd_cnt"}, rd_q.size(), 32);
    for (int k = 0; k < rd_q.size() && k < 32; k++) begin
      exp_a = (k < 16) ? k : (((k - 16) % 4) * 4 + (k - 16) / 4);
      chk($sformatf("%s_rd_addr[%0d]", name, k), rd_q[k], exp_a);
    end
    for (int k = 0; k < tl_q.size() && k < 32; k++)
      chk($sformatf("%s_tlast[%0d]", name, k), tl_q[k], ((k % 4) == 3) ? 1 : 0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_ctrl"}, {busy, done, pass, cfg_tvalid, rd_en, s_tvalid, s_tlast, wr_en}, 0);
    chk({name, "_rd_addr"}, rd_addr, 0);
    chk({name, "_wr_addr"}, wr_addr, 0);
    chk({name, "_cfg_tdata"}, cfg_tdata, 16'h0001);
  endtask

  initial begin
    bit ok;
    int good;
    bit prev_err;

    tbl[0] = '{rnd: 1'b0, inj: 1'b0, exp_err: 1'b0, exp_at2: 1'b0, exp_next: 1'b0};
    tbl[1] = '{rnd: 1'b1, inj: 1'b0, exp_err: 1'b0, exp_at2: 1'b0, exp_next: 1'b0};
    tbl[2] = '{rnd: 1'b0, inj: 1'b1, exp_err: 1'b1, exp_at2: 1'b0, exp_next: 1'b1};
    tbl[3] = '{rnd: 1'b1, inj: 1'b0, exp_err: 1'b0, exp_at2: 1'b0, exp_next: 1'b0};

    reset = 1'b0; start = 1'b0; cfg_tready = 1'b1;
    rnd_ready = 1'b0; inj = 1'b0;
    clear_stats();

    #1;
    check_idle_outputs("reset_hold");
    chk("reset_err", err, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Table-driven transforms
    prev_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      chk({nm, "_err_before"}, err, prev_err);
      clear_stats();
      rnd_ready = tbl[i].rnd;
      inj       = tbl[i].inj;
      pulse_start();
      @(negedge clk);
      chk({nm, "_err_clr_on_start"}, err, 0);
      wait_done(nm);
      check_full(nm);
      chk({nm, "_err"}, err, tbl[i].exp_err);
      chk({nm, "_err_at_idx2"}, err_at2, tbl[i].exp_at2);
      chk({nm, "_err_next"}, err_next, tbl[i].exp_next);
      prev_err = tbl[i].exp_err;
    end
    rnd_ready = 1'b0;
    inj = 1'b0;

    // Config stall: cfg_tready low for 10 cycles in CFG0
    clear_stats();
    cfg_tready = 1'b0;
    pulse_start();
    good = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cfg_tvalid && cfg_tdata == 16'h0001 && !rd_en && !pass) good++;
    end
    chk("cfg_stall_cycles", good, 10);
    chk("cfg_stall_rd_cnt", rd_q.size(), 0);
    @(posedge clk); #1 cfg_tready = 1'b1;
    wait_done("cfg_stall");
    check_full("cfg_stall");

    // Reset at oc = 7 in the row pass, then a clean transform
    clear_stats();
    pulse_start();
    wait_write(1'b0, 7, ok);
    chk("rst_mid_reach_oc7", ok, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_busy", busy, 0);
    clear_stats();
    pulse_start();
    wait_done("rst_rerun");
    check_full("rst_rerun");
    chk("rst_rerun_err", err, 0);

    // start pulsed during RUN1 and during FIN must be ignored
    clear_stats();
    pulse_start();
    wait_write(1'b1, 5, ok);
    chk("ign_reach_run1", ok, 1);
    pulse_start();
    wait_write(1'b1, 15, ok);
    chk("ign_reach_last", ok, 1);
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    chk("ign_fin_coincide", done, 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(negedge clk);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_wr_cnt", wr_cnt, 32);
    chk("ign_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
